// File: rtl/hash_rx.sv
// UART 8N1 receiver that assembles 16 bytes into a 128-bit MD5 target; target_valid rises 1 cycle after byte 15's stop sample.
// No back-pressure: a new target overwrites an unacknowledged one and pulses overrun.
module hash_rx #(
    parameter int fsm_clk_freq = 16000000,
    parameter int baud         = 115200,
    parameter int timeout_bits = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx,
    output logic [0:127] target,
    output logic         target_valid,
    input  logic         target_ack,
    output logic         frame_err,
    output logic         overrun,
    output logic         rx_led
);
    localparam int P  = fsm_clk_freq / baud;
    localparam int H  = P / 2;
    localparam int TO = timeout_bits * P;
    localparam int CW = $clog2(P + 1);
    localparam int IW = $clog2(TO + 1);
    localparam logic [CW-1:0] P_LAST  = CW'(P - 1);
    localparam logic [CW-1:0] H_LAST  = CW'(H - 1);
    localparam logic [IW-1:0] TO_LAST = IW'(TO - 1);
    localparam logic [IW-1:0] TO_SAT  = IW'(TO);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state;
    logic           rx_meta, rx_sync;
    logic [CW-1:0]  cnt;
    logic [IW-1:0]  idle_cnt;
    logic [2:0]     bit_idx;
    logic [3:0]     byte_idx;
    logic [7:0]     shreg;
    logic [0:127]   shadow;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign rx_led = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            idle_cnt     <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            shreg        <= '0;
            shadow       <= '0;
            target       <= '0;
            target_valid <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (target_ack && target_valid)
                target_valid <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_sync) begin
                        state    <= START;
                        idle_cnt <= '0;
                    end else begin
                        if (idle_cnt != TO_SAT)
                            idle_cnt <= idle_cnt + 1'b1;
                        // Abandon a stalled partial frame so the next byte starts a fresh target.
                        if (idle_cnt >= TO_LAST && byte_idx != 4'd0)
                            byte_idx <= 4'd0;
                    end
                end
                START: begin
                    if (cnt == H_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == P_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == P_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_sync) begin
                            shadow[{byte_idx, 3'b000} +: 8] <= shreg;
                            byte_idx <= byte_idx + 4'd1;
                            if (byte_idx == 4'd15) begin
                                target       <= {shadow[0:119], shreg};
                                target_valid <= 1'b1;
                                // An ack landing on the completion cycle consumes the old target.
                                if (target_valid && !target_ack)
                                    overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            byte_idx  <= 4'd0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hash_rx.sv
// Directed bench for hash_rx: frames, framing errors, glitches, idle timeout, overrun/ack and mid-frame reset.
module tb_hash_rx;
    localparam int CLK_HZ = 16000000;
    localparam int BAUD   = 400000;
    localparam int TOB    = 20;
    localparam int P      = CLK_HZ / BAUD;   // 40
    localparam int H      = P / 2;           // 20
    // Edge, counted from the start-bit drive, on which the stop bit is sampled.
    localparam int STOP_EDGE = 3 + H + 9 * P;

    localparam logic [127:0] F1 = 128'he4cec1b40fa014fe06f207755a9c2087;
    localparam logic [127:0] F2 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] F3 = 128'h5a5a00ffa5c33c817e18e700ff123400;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx = 1'b1;
    logic [0:127] target;
    logic         target_valid;
    logic         target_ack = 1'b0;
    logic         frame_err;
    logic         overrun;
    logic         rx_led;

    int n_chk = 0;
    int n_fail = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int ovr_base;
    logic led_seen = 1'b0;
    logic pre_valid, post_valid;

    hash_rx #(.fsm_clk_freq(CLK_HZ), .baud(BAUD), .timeout_bits(TOB)) dut (
        .clk(clk), .reset(reset), .rx(rx), .target(target),
        .target_valid(target_valid), .target_ack(target_ack),
        .frame_err(frame_err), .overrun(overrun), .rx_led(rx_led)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (rx_led) led_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic ack_done);
        rx = 1'b0;
        cycles(P);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(P);
        end
        rx = stop_ok;
        cycles(STOP_EDGE - 9 * P - 1);
        pre_valid = target_valid;
        if (ack_done) target_ack = 1'b1;
        cycles(1);
        post_valid = target_valid;
        target_ack = 1'b0;
        rx = 1'b1;
        cycles(P - (STOP_EDGE - 9 * P));
        if (!stop_ok) cycles(P);
    endtask

    task automatic send_frame(input logic [127:0] f, input int nbytes, input logic ack_last);
        for (int n = 0; n < nbytes; n++)
            send_byte(f[127 - 8 * n -: 8], 1'b1, ack_last && (n == 15));
    endtask

    task automatic ack_pulse();
        target_ack = 1'b1;
        cycles(1);
        target_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " target"}, target, '0);
        check({tag, " valid"}, {127'd0, target_valid}, 128'd0);
        check({tag, " frame_err"}, {127'd0, frame_err}, 128'd0);
        check({tag, " overrun"}, {127'd0, overrun}, 128'd0);
        check({tag, " rx_led"}, {127'd0, rx_led}, 128'd0);
    endtask

    initial begin
        cycles(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        cycles(2 * P);

        // Bad stop bit after 5 good bytes, then a full frame
        send_frame(F2, 5, 1'b0);
        send_byte(8'h3c, 1'b0, 1'b0);
        check("ferr count", 128'(ferr_cnt), 128'd1);
        check("ferr target kept", target, '0);
        check("ferr valid", {127'd0, target_valid}, 128'd0);
        send_frame(F1, 16, 1'b0);
        check("f1 pre valid", {127'd0, pre_valid}, 128'd0);
        check("f1 post valid", {127'd0, post_valid}, 128'd1);
        check("f1 target", target, F1);
        check("f1 no overrun", 128'(ovr_cnt), 128'd0);
        ack_pulse();
        check("ack clears valid", {127'd0, target_valid}, 128'd0);

        // Short low glitch on idle line
        led_seen = 1'b0;
        rx = 1'b0;
        cycles(12);
        rx = 1'b1;
        cycles(2 * P);
        check("glitch led seen", {127'd0, led_seen}, 128'd1);
        check("glitch led idle", {127'd0, rx_led}, 128'd0);
        check("glitch no ferr", 128'(ferr_cnt), 128'd1);
        check("glitch target kept", target, F1);

        // Partial frame abandoned by idle timeout
        send_frame(F3, 7, 1'b0);
        cycles(21 * P);
        send_frame(F2, 16, 1'b0);
        check("timeout target", target, F2);
        check("timeout valid", {127'd0, target_valid}, 128'd1);
        ack_pulse();

        // Back-to-back frames without ack, then ack on the completion cycle
        ovr_base = ovr_cnt;
        send_frame(F3, 16, 1'b0);
        check("A no overrun", 128'(ovr_cnt - ovr_base), 128'd0);
        send_frame(F1, 16, 1'b0);
        check("B overrun once", 128'(ovr_cnt - ovr_base), 128'd1);
        check("B target", target, F1);
        check("B valid", {127'd0, target_valid}, 128'd1);
        send_frame(F2, 16, 1'b1);
        check("C post valid", {127'd0, post_valid}, 128'd1);
        check("C valid held", {127'd0, target_valid}, 128'd1);
        check("C no overrun", 128'(ovr_cnt - ovr_base), 128'd1);
        check("C target", target, F2);

        // Reset after the 4th data bit of byte 9
        send_frame(F1, 9, 1'b0);
        rx = 1'b0;
        cycles(P);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            cycles(P);
        end
        reset = 1'b1;
        rx = 1'b1;
        cycles(3);
        check_reset_outputs("midframe reset");
        reset = 1'b0;
        cycles(2 * P);
        send_frame(F3, 16, 1'b0);
        check("post reset target", target, F3);
        check("post reset valid", {127'd0, target_valid}, 128'd1);
        check("final ferr count", 128'(ferr_cnt), 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hash_rx.md
HASH_RX -- requirements
Module: hash_rx

Interface
REQ-001 SHALL have parameter fsm_clk_freq, default 16000000, system clock frequency in Hz.
REQ-002 SHALL have parameter baud, default 115200, serial bit rate.
REQ-003 SHALL have parameter timeout_bits, default 20, inter-byte idle limit in bit periods.
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port target  output  128 [0:127]  assembled 16-byte MD5 target.
REQ-008 SHALL have port target_valid  output  1  high while an unacknowledged target is held.
REQ-009 SHALL have port target_ack  input  1  consumer acknowledge, sampled on rising edge.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a new target replaces an unacknowledged one.
REQ-012 SHALL have port rx_led  output  1  high whenever the bit FSM is not IDLE.

Function
REQ-013 SHALL define bit period P = fsm_clk_freq / baud, integer division (138 at defaults), and half period H = P / 2.
REQ-014 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value.
REQ-015 SHALL implement bit FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: synchronized rx low -> START, clear counter.
REQ-017 START: after H cycles, sample rx; low -> DATA with bit index 0; high -> IDLE (glitch, no error).
REQ-018 DATA: every P cycles sample one bit into shift register, LSB first; after bit index 7 -> STOP.
REQ-019 STOP: after P cycles sample rx; high -> byte accepted, IDLE; low -> frame_err pulse, byte discarded, byte index reset to 0, IDLE.
REQ-020 SHALL keep a 4-bit byte index; accepted byte n is written into shadow bits [8n:8n+7]; the first received byte lands in [0:7].
REQ-021 On acceptance of byte index 15, SHALL copy the shadow into target, set target_valid the following cycle, and wrap the byte index to 0.
REQ-022 target SHALL not change except at the REQ-021 copy; partial frames never alter target.
REQ-023 target_ack high while target_valid high SHALL clear target_valid next cycle; ack while target_valid low SHALL be ignored.
REQ-024 Frame completion in the same cycle as ack: new target loads, target_valid stays 1, no overrun pulse.
REQ-025 Frame completion while target_valid is 1 with no ack that cycle: new target loads, target_valid stays 1, overrun pulses for one cycle.
REQ-026 Bytes SHALL continue to be received while target_valid is high; no back-pressure on rx.
REQ-027 With byte index nonzero, if the FSM stays IDLE for timeout_bits*P consecutive cycles, byte index SHALL reset to 0; shadow contents are don't-care.
REQ-028 The idle counter SHALL saturate and clear on every transition out of IDLE.
REQ-029 Latency: target_valid rises exactly 1 cycle after the stop-bit sample cycle of byte 15.

Reset
REQ-030 On reset, SHALL enter IDLE with byte index 0, all counters 0, synchronizer flops 1.
REQ-031 On reset, outputs SHALL be target = 0, target_valid = 0, frame_err = 0, overrun = 0, rx_led = 0.
REQ-032 Reset asserted mid-byte or mid-frame SHALL discard all partial data; the next start bit after release begins byte 0.

Verification
REQ-033 Send bytes e4 ce c1 b4 0f a0 14 fe 06 f2 07 75 5a 9c 20 87 at 115200 -> target = 128'he4cec1b40fa014fe06f207755a9c2087, target_valid = 1, one cycle after the last stop sample.
REQ-034 Send a byte with stop bit low after 5 good bytes -> one frame_err pulse, byte index 0, target unchanged; the following 16 good bytes -> correct target.
REQ-035 Low pulse of 40 cycles (< H = 69) on idle rx -> FSM returns to IDLE, no byte, no frame_err.
REQ-036 Send 7 bytes, hold rx high 21*138 cycles, send 16 bytes -> target equals the later 16 bytes only.
REQ-037 Two back-to-back frames, no ack -> overrun pulses once at the second completion, target = second frame; ack asserted on the completion cycle of a third frame -> target_valid stays 1, no overrun.
REQ-038 Assert reset after the 4th data bit of byte 9 -> all outputs 0; a fresh 16-byte frame then completes correctly.
